// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, sequencer states and default timing for the
// init/refresh scheduler and the CPU access engine.
package sdram_pkg;

    typedef logic [2:0] cmd_t;   // {~WE, ~RAS, ~CAS}

    localparam cmd_t CMD_NOP = 3'b111;
    localparam cmd_t CMD_PRE = 3'b001;
    localparam cmd_t CMD_REF = 3'b100;
    localparam cmd_t CMD_LMR = 3'b000;

    typedef enum logic [3:0] {
        PWRUP_WAIT,
        PRE,
        WAIT_RP,
        INIT_REF,
        WAIT_RFC_I,
        LMR,
        WAIT_MRD,
        IDLE,
        REF,
        WAIT_RFC,
        GRANT
    } state_t;

    // 25 MHz CPU clock
    localparam int          T_POWERUP_DEF      = 5000;
    localparam int          T_RP_DEF           = 2;
    localparam int          T_RFC_DEF          = 7;
    localparam int          T_MRD_DEF          = 2;
    localparam int          INIT_REFRESHES_DEF = 8;
    localparam int          REF_INTERVAL_DEF   = 390;
    localparam int          DEBT_MAX_DEF       = 7;
    localparam int          CAS_LATENCY        = 2;
    localparam int          BURST_LEN          = 4;
    localparam logic [11:0] MODE_REG_DEF       = 12'h022;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter feeding a saturating count of owed auto-refreshes.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int DEBT_MAX     = DEBT_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       dec,
    output logic [2:0] debt
);

    localparam int IW = $clog2(REF_INTERVAL + 1);

    logic [IW-1:0] cnt;
    logic          tick;

    assign tick = tick_en && (cnt == IW'(REF_INTERVAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (tick_en) cnt <= tick ? '0 : cnt + IW'(1);
    end

    // A tick and a refresh issue in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            debt <= '0;
        else if (tick && !dec && debt != 3'(DEBT_MAX))
            debt <= debt + 3'd1;
        else if (dec && !tick && debt != 3'd0)
            debt <= debt - 3'd1;
    end

endmodule

// File: rtl/sdram_init_refresh_sched.sv
// SDRAM power-up init sequencer and auto-refresh scheduler; hands the command
// bus to the access engine through acc_req/acc_gnt when no refresh is owed.
module sdram_init_refresh_sched
    import sdram_pkg::*;
#(
    parameter int          T_POWERUP      = T_POWERUP_DEF,
    parameter int          T_RP           = T_RP_DEF,
    parameter int          T_RFC          = T_RFC_DEF,
    parameter int          T_MRD          = T_MRD_DEF,
    parameter int          INIT_REFRESHES = INIT_REFRESHES_DEF,
    parameter int          REF_INTERVAL   = REF_INTERVAL_DEF,
    parameter logic [11:0] MODE_REG       = MODE_REG_DEF,
    parameter int          DEBT_MAX       = DEBT_MAX_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        acc_req,
    input  logic        acc_done,
    output logic        acc_gnt,
    output logic        own_bus,
    output logic        init_done,
    output logic        SDRAM_CLK_EN,
    output logic        SDRAM_CS,
    output logic [2:0]  SDRAM_CMD,
    output logic [11:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    output logic [2:0]  ref_debt
);

    localparam int CW = 16;
    localparam int RW = 8;

    state_t        state, state_n, idle_pick;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          dec;
    cmd_t          cmd_n;
    logic [11:0]   a_n;

    // IDLE is folded into the end of WAIT_RFC so refreshes run T_RFC apart.
    assign idle_pick = (ref_debt != 3'd0) ? REF : (acc_req ? GRANT : IDLE);
    assign dec       = (state_n == REF);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        rcnt_n  = rcnt;
        unique case (state)
            PWRUP_WAIT: if (cnt == CW'(T_POWERUP)) state_n = PRE;
            PRE:        state_n = WAIT_RP;
            WAIT_RP:    if (cnt == CW'(T_RP - 2)) state_n = INIT_REF;
            INIT_REF: begin
                state_n = WAIT_RFC_I;
                rcnt_n  = rcnt + RW'(1);
            end
            WAIT_RFC_I: if (cnt == CW'(T_RFC - 2))
                            state_n = (rcnt == RW'(INIT_REFRESHES)) ? LMR : INIT_REF;
            LMR:        state_n = WAIT_MRD;
            WAIT_MRD:   if (cnt == CW'(T_MRD - 2)) state_n = IDLE;
            IDLE:       state_n = idle_pick;
            REF:        state_n = WAIT_RFC;
            WAIT_RFC:   if (cnt == CW'(T_RFC - 2)) state_n = idle_pick;
            GRANT:      if (acc_done) state_n = IDLE;
            default:    state_n = PWRUP_WAIT;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    always_comb begin
        cmd_n = CMD_NOP;
        a_n   = 12'h000;
        unique case (state_n)
            PRE: begin
                cmd_n = CMD_PRE;
                a_n   = 12'h400;
            end
            INIT_REF, REF: cmd_n = CMD_REF;
            LMR: begin
                cmd_n = CMD_LMR;
                a_n   = MODE_REG;
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= PWRUP_WAIT;
            cnt          <= '0;
            rcnt         <= '0;
            SDRAM_CLK_EN <= 1'b0;
            SDRAM_CS     <= 1'b1;
            SDRAM_CMD    <= CMD_NOP;
            SDRAM_A      <= 12'h000;
            SDRAM_BA     <= 2'b00;
            acc_gnt      <= 1'b0;
            own_bus      <= 1'b1;
            init_done    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rcnt         <= rcnt_n;
            SDRAM_CLK_EN <= 1'b1;
            SDRAM_CS     <= (state_n == GRANT);
            SDRAM_CMD    <= cmd_n;
            SDRAM_A      <= a_n;
            SDRAM_BA     <= 2'b00;
            acc_gnt      <= (state_n == GRANT);
            own_bus      <= (state_n != GRANT);
            if (state_n == IDLE) init_done <= 1'b1;
        end
    end

    sdram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .DEBT_MAX     (DEBT_MAX)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RESET),
        .tick_en (init_done),
        .dec     (dec),
        .debt    (ref_debt)
    );

endmodule

// File: tb/tb_sdram_init_refresh_sched.sv
// Randomized bench for sdram_init_refresh_sched against a timeline/debt model.
module tb_sdram_init_refresh_sched;

    localparam int TP = 10, TRP = 2, TRFC = 3, NREF = 2, TMRD = 2, RI = 20, DMAX = 7;
    localparam logic [11:0] MODE = 12'h022;
    localparam int LMR_K  = TP + TRP + NREF * TRFC;
    localparam int IDLE_K = LMR_K + TMRD;

    logic        CLK = 1'b0, RESET = 1'b0, acc_req = 1'b0, acc_done = 1'b0;
    logic        acc_gnt, own_bus, init_done, SDRAM_CLK_EN, SDRAM_CS;
    logic [2:0]  SDRAM_CMD, ref_debt;
    logic [11:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;

    sdram_init_refresh_sched #(
        .T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
        .INIT_REFRESHES(NREF), .REF_INTERVAL(RI), .MODE_REG(MODE), .DEBT_MAX(DMAX)
    ) dut (
        .CLK(CLK), .RESET(RESET), .acc_req(acc_req), .acc_done(acc_done),
        .acc_gnt(acc_gnt), .own_bus(own_bus), .init_done(init_done),
        .SDRAM_CLK_EN(SDRAM_CLK_EN), .SDRAM_CS(SDRAM_CS), .SDRAM_CMD(SDRAM_CMD),
        .SDRAM_A(SDRAM_A), .SDRAM_BA(SDRAM_BA), .ref_debt(ref_debt)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int k, debt, free_at, hold, max_debt;
    bit granted, req_on, long_next;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s @k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; debt = 0; granted = 0; free_at = IDLE_K + 1; hold = 0;
    endtask

    // Advance the model by one edge using the inputs applied before it, then compare.
    task automatic step();
        logic [2:0]  ec;
        logic [11:0] ea;
        bit chk_a, tick, dec;
        ec = 3'b111; ea = 12'h000; chk_a = 0; tick = 0; dec = 0;
        if (k < IDLE_K) begin
            if (k == TP) begin ec = 3'b001; ea = 12'h400; chk_a = 1; end
            else if (k >= TP + TRP && k < LMR_K && (k - TP - TRP) % TRFC == 0) ec = 3'b100;
            else if (k == LMR_K) begin ec = 3'b000; ea = MODE; chk_a = 1; end
        end else if (k > IDLE_K) begin
            tick = ((k - IDLE_K) % RI == 0);
            if (granted) begin
                if (acc_done) begin granted = 0; free_at = k + 1; end
            end else if (k >= free_at) begin
                if (debt > 0) begin ec = 3'b100; dec = 1; free_at = k + TRFC; end
                else if (acc_req) granted = 1;
            end
            if (tick && !dec && debt < DMAX) debt++;
            else if (dec && !tick) debt--;
        end
        chk("cmd", 32'(SDRAM_CMD), 32'(ec));
        if (chk_a) chk("addr", 32'(SDRAM_A), 32'(ea));
        chk("ba", 32'(SDRAM_BA), 32'd0);
        chk("cke", 32'(SDRAM_CLK_EN), 32'd1);
        if (!granted) chk("cs", 32'(SDRAM_CS), 32'd0);
        chk("acc_gnt", 32'(acc_gnt), 32'(granted));
        chk("own_bus", 32'(own_bus), 32'(!granted));
        chk("init_done", 32'(init_done), 32'(k >= IDLE_K));
        chk("ref_debt", 32'(ref_debt), 32'(debt));
        if (int'(ref_debt) > max_debt) max_debt = int'(ref_debt);
        k++;
    endtask

    task automatic drive();
        acc_done = 1'b0;
        if (granted) begin
            acc_req = 1'b0;
            if (hold == 0) acc_done = 1'b1;
            else hold--;
        end else begin
            if (req_on && !acc_req && $urandom_range(0, 3) == 0) begin
                acc_req = 1'b1;
                hold = long_next ? 10 * RI : int'($urandom_range(0, 8));
                long_next = 0;
            end
            if ($urandom_range(0, 15) == 0) acc_done = 1'b1;   // stray, must be ignored
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            step();
            drive();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cke"}, 32'(SDRAM_CLK_EN), 32'd0);
        chk({tag, "_cs"}, 32'(SDRAM_CS), 32'd1);
        chk({tag, "_cmd"}, 32'(SDRAM_CMD), 32'h7);
        chk({tag, "_addr"}, 32'(SDRAM_A), 32'd0);
        chk({tag, "_ba"}, 32'(SDRAM_BA), 32'd0);
        chk({tag, "_gnt"}, 32'(acc_gnt), 32'd0);
        chk({tag, "_own"}, 32'(own_bus), 32'd1);
        chk({tag, "_init"}, 32'(init_done), 32'd0);
        chk({tag, "_debt"}, 32'(ref_debt), 32'd0);
    endtask

    initial begin
        bit got;
        max_debt = 0; req_on = 0; long_next = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 chk_reset_vals("rst");

        @(negedge CLK) RESET = 1'b1;
        run(150);                   // init sequence, then refresh only
        req_on = 1;
        run(500);                   // mixed grants, refreshes, stray acc_done
        long_next = 1;
        run(400);                   // one grant held 10 intervals
        chk("debt_saturated", 32'(max_debt), 32'(DMAX));

        long_next = 1;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge CLK); #1;
            step();
            drive();
            if (granted && hold > 2) got = 1;
        end
        chk("grant_before_reset", 32'(got), 32'd1);
        #2 RESET = 1'b0;
        #1 chk_reset_vals("midrst");
        acc_req = 1'b0; acc_done = 1'b0;
        model_reset();
        @(negedge CLK) RESET = 1'b1;
        run(200);                   // full init reruns, acc_req held off until done

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
